// File: rtl/hilo_divider_if.sv
// hilo_divider_if
// Request/response bundle between the ALU and the HI/LO divider.
//   signed_div_i : 1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high until ready_o is seen
//   annul_i      : abort an in-flight divide (pipeline flush)
//   result_o     : {remainder, quotient}, zero while ready_o is low
//   ready_o      : result valid
// The master modport is the ALU side; the slave modport is the divider.
interface hilo_divider_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/hilo_divider.sv
// hilo_divider
// Multi-cycle radix-2 restoring divider for DIV/DIVU. One quotient bit is
// resolved per clock; a non-zero divide takes 32 iterations after the start
// edge, a divide by zero finishes after one extra cycle with a zero result.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : hilo_divider_if slave modport (operands, start/annul, result/ready)
// Outputs result_o and ready_o come straight from flops.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    hilo_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    // Two's-complement magnitude of v when neg is set, raw value otherwise.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        logic [WIDTH-1:0] m;
        if (neg) begin
            m = ~v + WIDTH'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t             state_r,     state_s;
    logic [CW-1:0]      cnt_r,       cnt_s;
    logic [WIDTH-1:0]   rem_r,       rem_s;      // upper partial remainder
    logic [WIDTH-1:0]   quot_r,      quot_s;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   divisor_r,   divisor_s;
    logic               dvd_neg_r,   dvd_neg_s;
    logic               dvs_neg_r,   dvs_neg_s;
    logic [2*WIDTH-1:0] result_r,    result_s;
    logic               ready_r,     ready_s;

    // Trial subtract: {rem, next dividend bit} - divisor. Because the
    // partial remainder is always below the divisor, the 33-bit result's
    // top bit is a reliable sign.
    logic [WIDTH:0]     partial_s;
    logic [WIDTH:0]     trial_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   rem_step_s;
    logic [WIDTH-1:0]   quot_step_s;

    assign partial_s   = {rem_r, quot_r[WIDTH-1]};
    assign trial_s     = partial_s - {1'b0, divisor_r};
    assign q_bit_s     = ~trial_s[WIDTH];
    assign rem_step_s  = q_bit_s ? trial_s[WIDTH-1:0] : partial_s[WIDTH-1:0];
    assign quot_step_s = {quot_r[WIDTH-2:0], q_bit_s};

    // Next-state and next-datapath logic for the divide FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rem_s     = rem_r;
        quot_s    = quot_r;
        divisor_s = divisor_r;
        dvd_neg_s = dvd_neg_r;
        dvs_neg_s = dvs_neg_r;
        result_s  = result_r;
        ready_s   = ready_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == {WIDTH{1'b0}}) begin
                        state_s = ST_BYZERO;
                    end else begin
                        state_s   = ST_ON;
                        cnt_s     = {CW{1'b0}};
                        rem_s     = {WIDTH{1'b0}};
                        dvd_neg_s = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                        dvs_neg_s = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
                        quot_s    = magnitude(bus.opdata1_i,
                                              bus.signed_div_i & bus.opdata1_i[WIDTH-1]);
                        divisor_s = magnitude(bus.opdata2_i,
                                              bus.signed_div_i & bus.opdata2_i[WIDTH-1]);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_BYZERO: begin
                state_s  = ST_END;
                result_s = {(2*WIDTH){1'b0}};
                ready_s  = 1'b1;
            end

            ST_ON: begin
                if (bus.annul_i) begin
                    // Flush: drop the partial result, no ready pulse.
                    state_s = ST_IDLE;
                    cnt_s   = {CW{1'b0}};
                    rem_s   = {WIDTH{1'b0}};
                    quot_s  = {WIDTH{1'b0}};
                end else begin
                    rem_s  = rem_step_s;
                    quot_s = quot_step_s;
                    cnt_s  = cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        // Last bit resolved: quotient negated on differing
                        // signs, remainder follows the dividend's sign.
                        state_s  = ST_END;
                        cnt_s    = {CW{1'b0}};
                        ready_s  = 1'b1;
                        result_s = {magnitude(rem_step_s, dvd_neg_r),
                                    magnitude(quot_step_s, dvd_neg_r ^ dvs_neg_r)};
                    end else begin
                        state_s = ST_ON;
                    end
                end
            end

            ST_END: begin
                if (!bus.start_i) begin
                    state_s  = ST_IDLE;
                    ready_s  = 1'b0;
                    result_s = {(2*WIDTH){1'b0}};
                end else begin
                    state_s = ST_END;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                cnt_s    = {CW{1'b0}};
                ready_s  = 1'b0;
                result_s = {(2*WIDTH){1'b0}};
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quot_r    <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            dvd_neg_r <= 1'b0;
            dvs_neg_r <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rem_r     <= rem_s;
            quot_r    <= quot_s;
            divisor_r <= divisor_s;
            dvd_neg_r <= dvd_neg_s;
            dvs_neg_r <= dvs_neg_s;
            result_r  <= result_s;
            ready_r   <= ready_s;
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider
// Directed bench for hilo_divider: each task drives one scenario and checks
// the outputs against hand-computed {remainder, quotient} values and cycle
// counts. Inputs change and outputs are sampled on the falling edge.
module tb_hilo_divider;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    hilo_divider_if #(.WIDTH(32)) bus ();

    hilo_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a request and wait (bounded) for ready_o. lat counts falling
    // edges after the launch; 33 means ready after E32. start_i stays high.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input bit scramble,
                           output logic [63:0] res, output int lat,
                           output bit zero_ok);
        @(negedge clk);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        lat     = 40;
        zero_ok = 1'b1;
        res     = 64'd0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) begin
                res = bus.result_o;
                lat = i;
                break;
            end
            if (bus.result_o !== 64'd0) zero_ok = 1'b0;
            if (scramble) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~bus.signed_div_i;
            end
        end
    endtask

    // Check one completed request, then drop start_i and check the return to idle.
    task automatic check_div(input string name, input logic [31:0] a,
                             input logic [31:0] b, input logic sgn,
                             input bit scramble, input logic [63:0] exp,
                             input int exp_lat);
        logic [63:0] res;
        int          lat;
        bit          zero_ok;
        run_div(a, b, sgn, scramble, res, lat, zero_ok);
        n_checks++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (res !== exp) $display("FAIL %s result: got %h expected %h", name, res, exp);
        else n_pass++;
        n_checks++;
        if (zero_ok !== 1'b1) $display("FAIL %s result_zero_while_busy: got %0d expected 1", name, zero_ok);
        else n_pass++;
        bus.start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ready_o, bus.result_o} !== 65'd0)
            $display("FAIL %s drop: got ready=%0d result=%h expected ready=0 result=0",
                     name, bus.ready_o, bus.result_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd0; bus.opdata2_i = 32'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.ready_o, bus.result_o} !== 65'd0)
            $display("FAIL reset_state: got ready=%0d result=%h expected ready=0 result=0",
                     bus.ready_o, bus.result_o);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        check_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 64'h00000002_0000000E, 33);
    endtask

    task automatic test_signed();
        check_div("div_m7_2",    32'hFFFFFFF9, 32'd2,        1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 33);
        check_div("div_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 1'b0, 64'hFFFFFFFE_0000000E, 33);
        check_div("div_100_m7",  32'd100,      32'hFFFFFFF9, 1'b1, 1'b0, 64'h00000002_FFFFFFF2, 33);
    endtask

    task automatic test_overflow();
        check_div("div_ovf",  32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h00000000_80000000, 33);
        check_div("divu_big", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h80000000_00000000, 33);
    endtask

    task automatic test_div_zero();
        check_div("div_zero", 32'd1234, 32'd0, 1'b0, 1'b0, 64'd0, 2);
    endtask

    task automatic test_abort();
        bit seen_ready;
        @(negedge clk);
        bus.opdata1_i = 32'd999; bus.opdata2_i = 32'd3;
        bus.signed_div_i = 1'b0; bus.start_i = 1'b1;
        @(negedge clk);                    // after E0
        repeat (9) @(negedge clk);         // after E9
        bus.annul_i = 1'b1;                // sampled at E10
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0) seen_ready = 1'b1;
        end
        n_checks++;
        if (seen_ready !== 1'b0) $display("FAIL abort_no_ready: got ready pulse expected none");
        else n_pass++;
        check_div("after_abort_50_5", 32'd50, 32'd5, 1'b0, 1'b0, 64'h00000000_0000000A, 33);
    endtask

    task automatic test_operand_stability();
        check_div("stable_1000_10", 32'd1000, 32'd10, 1'b0, 1'b1, 64'h00000000_00000064, 33);
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int          lat;
        bit          zero_ok;
        // Mid-divide reset, then a full-latency request proves the FSM restarted in IDLE.
        @(negedge clk);
        bus.opdata1_i = 32'd500; bus.opdata2_i = 32'd7;
        bus.signed_div_i = 1'b0; bus.start_i = 1'b1;
        repeat (15) @(posedge clk);
        #2 rst = 1'b0;
        bus.start_i = 1'b0;
        #1;
        n_checks++;
        if ({bus.ready_o, bus.result_o} !== 65'd0)
            $display("FAIL reset_mid_divide: got ready=%0d result=%h expected 0",
                     bus.ready_o, bus.result_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        check_div("after_reset_500_7", 32'd500, 32'd7, 1'b0, 1'b0, 64'h00000003_00000047, 33);
        // Reset while the result is being presented clears the outputs between edges.
        run_div(32'd9, 32'd4, 1'b0, 1'b0, res, lat, zero_ok);
        n_checks++;
        if (res !== 64'h00000001_00000002) $display("FAIL pre_reset_result: got %h expected %h", res, 64'h00000001_00000002);
        else n_pass++;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.ready_o, bus.result_o} !== 65'd0)
            $display("FAIL reset_in_end: got ready=%0d result=%h expected 0",
                     bus.ready_o, bus.result_o);
        else n_pass++;
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_held_start();
        logic [63:0] res;
        int          lat;
        bit          zero_ok;
        run_div(32'd77, 32'd5, 1'b0, 1'b0, res, lat, zero_ok);
        n_checks++;
        if (res !== 64'h00000002_0000000F) $display("FAIL held_result: got %h expected %h", res, 64'h00000002_0000000F);
        else n_pass++;
        bus.opdata1_i = 32'd1;             // a restart would produce a different result
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({bus.ready_o, bus.result_o} !== {1'b1, 64'h00000002_0000000F})
                $display("FAIL held_hold: got ready=%0d result=%h expected ready=1 result=%h",
                         bus.ready_o, bus.result_o, 64'h00000002_0000000F);
            else n_pass++;
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ready_o, bus.result_o} !== 65'd0)
            $display("FAIL held_drop: got ready=%0d result=%h expected 0", bus.ready_o, bus.result_o);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_abort();
        test_operand_stability();
        test_async_reset();
        test_held_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_divider.md
# hilo_divider

Multi-cycle 32-bit signed/unsigned integer divider that serves the ALU's DIV/DIVU requests. It uses a start/ready handshake: the ALU raises `start_i` and stalls the pipeline until `ready_o` pulses. The block then returns `{remainder, quotient}`, which the ALU splits into HI (upper word) and LO (lower word). It uses a radix-2 restoring algorithm, one quotient bit per cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Only 32 is supported; the parameter documents the sizing.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with operands.
- `opdata1_i`  in  32  dividend (rs).
- `opdata2_i`  in  32  divisor (rt).
- `start_i`  in  1  request; held high by the ALU until it sees `ready_o`.
- `annul_i`  in  1  abort request, e.g. on a pipeline flush.
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; 0 whenever `ready_o`=0.
- `ready_o`  out  1  result valid; registered.

## Operation
- **States:** IDLE, BYZERO, ON, END. State, counter, operand and result registers are all flops.
- **Reset (`rst`=0, any time, including mid-divide):** state=IDLE, `ready_o`=0, `result_o`=0, counter=0, partial results cleared.
- **IDLE:**
  - `start_i`=1 and `annul_i`=0 and divisor=0 → BYZERO.
  - `start_i`=1 and `annul_i`=0 and divisor≠0 → ON. On this edge, latch the operand magnitudes and the signs of dividend and divisor. Magnitudes are two's-complement negated when `signed_div_i`=1 and bit 31=1; otherwise the raw value is used.
  - Otherwise stay in IDLE.
- **BYZERO:** next edge → END with `result_o`=64'h0.
- **ON:** 33-bit trial subtract of the divisor from the upper partial remainder.
  - Non-negative: keep the difference and shift in quotient bit 1.
  - Negative: keep the partial remainder and shift in 0.
  - Counter increments 0..31. At counter=31 the last bit is resolved; the edge loads `result_o` and sets `ready_o`=1, state → END.
  - Sign fix-up for signed divides:
    - Quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend.
  - `annul_i`=1 in ON → IDLE on the next edge, `ready_o` stays 0, the result is discarded.
  - Changes on `opdata1_i`/`opdata2_i`/`signed_div_i`/`start_i` during ON are ignored.
- **END:** `ready_o`=1 and `result_o` valid.
  - `start_i`=0 on the next edge → IDLE, with `ready_o`←0 and `result_o`←0.
  - `start_i`=1 → stay in END and hold the outputs. The same instruction is never re-executed.
- **Boundary results:**
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (wraps; no trap).
  - Divide by zero → quotient 0, remainder 0.
- **Priority:** `rst` > `annul_i` > `start_i`.

## Timing
- E0 = the rising edge that samples `start_i`=1 in IDLE.
- Divisor ≠ 0: iterations on edges E1..E32; `ready_o` rises after E32 (33-cycle latency from E0). Earliest new request is sampled at E34 (END→IDLE at E33).
- Divisor = 0: BYZERO after E0, END after E1; `ready_o` is high from E1.
- The ALU drops `start_i` combinationally when `ready_o`=1, so `ready_o` is a single-cycle pulse in normal use.
- Abort: `annul_i` high at edge Ek during ON → IDLE after Ek. No `ready_o` pulse occurs.
- Both outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Unsigned:** 100 / 7, `signed_div_i`=0, hold `start_i` → `ready_o` high after E32, `result_o`=0x00000002_0000000E; `ready_o` low one cycle after `start_i` drops.
- **Signed mixed signs:** 0xFFFFFFF9 (−7) / 2, `signed_div_i`=1 → `result_o`=0xFFFFFFFF_FFFFFFFD.
- **Signed overflow and unsigned large dividend:**
  - 0x80000000 / 0xFFFFFFFF signed → `result_o`=0x00000000_80000000.
  - Same operands unsigned → `result_o`=0x80000000_00000000.
- **Divide by zero:** 1234 / 0 → `ready_o` high after E1, `result_o`=0.
- **Abort and operand stability:**
  - Pulse `annul_i` at E10 → `ready_o` never rises and the state returns to IDLE. A new 50 / 5 request then yields 0x00000000_0000000A after 33 cycles.
  - Separately, toggling `opdata2_i` during ON does not change the result.
- **Reset and held start:**
  - Assert `rst`=0 mid-divide (async, between edges) → `ready_o`=0 and `result_o`=0 immediately.
  - Separately, hold `start_i`=1 through END for 3 cycles → `ready_o` stays 1 and the result is unchanged, with no restart.
